// File: rtl/exec_mem_unit_pkg.sv
// Shared types and constants for the execute/memory back half of the core.
// Holds the opcode and function-field encodings, the 32-bit word type and
// the data-memory probe word indices used when DMEM_PROBE_EN is defined.
package exec_mem_unit_pkg;

    typedef logic [31:0] word_t;
    typedef logic [5:0]  opcode_t;
    typedef logic [5:0]  func_t;
    typedef logic [4:0]  reg_idx_t;

    // Primary opcodes
    localparam opcode_t OP_R    = 6'd0;
    localparam opcode_t OP_ADDI = 6'd1;
    localparam opcode_t OP_LUI  = 6'd3;
    localparam opcode_t OP_ANDI = 6'd4;
    localparam opcode_t OP_ORI  = 6'd5;
    localparam opcode_t OP_XORI = 6'd6;
    localparam opcode_t OP_LW   = 6'd16;
    localparam opcode_t OP_LH   = 6'd18;
    localparam opcode_t OP_LB   = 6'd20;
    localparam opcode_t OP_SW   = 6'd24;
    localparam opcode_t OP_SH   = 6'd26;
    localparam opcode_t OP_SB   = 6'd28;
    localparam opcode_t OP_JAL  = 6'd41;
    localparam opcode_t OP_HALT = 6'd63;

    // R-type function codes
    localparam func_t FN_ADD = 6'd0;
    localparam func_t FN_SUB = 6'd2;
    localparam func_t FN_AND = 6'd8;
    localparam func_t FN_OR  = 6'd9;
    localparam func_t FN_XOR = 6'd10;
    localparam func_t FN_NOR = 6'd11;
    localparam func_t FN_SLL = 6'd16;
    localparam func_t FN_SRL = 6'd17;
    localparam func_t FN_SRA = 6'd18;

    // Word indices exposed by the optional memory probes (byte 532, 576, 900)
    localparam int PROBE_IDX_A = 133;
    localparam int PROBE_IDX_B = 144;
    localparam int PROBE_IDX_C = 225;

    function automatic logic is_store(input opcode_t op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/exec_mem_unit_if.sv
// Pipeline-side bus of exec_mem_unit: E1 operands in, E1 result and
// destination out (for forwarding), E2 opcode/destination/result out
// (towards the execute/write-back register).
interface exec_mem_unit_if;
    import exec_mem_unit_pkg::*;

    word_t    pc_e1;
    opcode_t  op_e1;
    reg_idx_t rt_e1;
    reg_idx_t rd_e1;
    logic [10:0] aux_e1;
    word_t    os_e1;
    word_t    ot_e1;
    word_t    imm_dpl_e1;

    reg_idx_t wreg_alu;
    word_t    alu_result_e1;
    opcode_t  op_e2;
    reg_idx_t wreg_e2;
    word_t    result_e2;

    // Decode/execute side: drives operands, consumes results
    modport master (
        output pc_e1, op_e1, rt_e1, rd_e1, aux_e1, os_e1, ot_e1, imm_dpl_e1,
        input  wreg_alu, alu_result_e1, op_e2, wreg_e2, result_e2
    );

    // The execute/memory unit itself
    modport slave (
        input  pc_e1, op_e1, rt_e1, rd_e1, aux_e1, os_e1, ot_e1, imm_dpl_e1,
        output wreg_alu, alu_result_e1, op_e2, wreg_e2, result_e2
    );

endinterface

// File: rtl/dmem_lane.sv
// One 8-bit byte lane of the data memory: asynchronous read, synchronous
// write with enable. Four of these side by side form the 32-bit data memory.
// With DMEM_PROBE_EN defined, three fixed words are also read out
// continuously on probe_a/probe_b/probe_c.
module dmem_lane
    import exec_mem_unit_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          sysclk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
`ifdef DMEM_PROBE_EN
    ,
    output logic [7:0]    probe_a,
    output logic [7:0]    probe_b,
    output logic [7:0]    probe_c
`endif
);

    logic [7:0] mem [DEPTH];

    // Byte write at the clock edge when enabled
    // NOTE: the storage array has no reset; clearing RAM would force it into flops, and contents legitimately survive a pipeline reset.
    always_ff @(posedge sysclk) begin
        if (we) begin
            // NOTE: sequential state uses non-blocking assignment so every reader sees pre-edge values.
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

`ifdef DMEM_PROBE_EN
    assign probe_a = mem[AW'(PROBE_IDX_A)];
    assign probe_b = mem[AW'(PROBE_IDX_B)];
    assign probe_c = mem[AW'(PROBE_IDX_C)];
`endif

endmodule

// File: rtl/exec_mem_unit.sv
// Execute/memory back half of the 5-stage core.
// E1: combinational ALU producing the result and destination register.
// E2: one pipeline register, a 4-lane byte-addressed data memory with
// asynchronous read, and the load/ALU result mux.
// Optional feature macro: DMEM_PROBE_EN adds dm133/dm144/dm225 word probes.
module exec_mem_unit
    import exec_mem_unit_pkg::*;
#(
    parameter int       DM_WORDS = 256,
    parameter reg_idx_t JAL_LINK = 5'd31
) (
    input  logic sysclk,
    input  logic cpu_reset,        // synchronous, active-high
    exec_mem_unit_if.slave bus
`ifdef DMEM_PROBE_EN
    ,
    output word_t dm133,
    output word_t dm144,
    output word_t dm225
`endif
);

    localparam int AW = $clog2(DM_WORDS);

    // ------------------------------------------------------------------
    // E1: ALU
    // ------------------------------------------------------------------
    logic [4:0] shamt;
    func_t      func;
    word_t      alu_result;
    reg_idx_t   wreg_sel;

    assign shamt = bus.aux_e1[10:6];
    assign func  = bus.aux_e1[5:0];

    // Result and destination for the instruction in E1; a zero destination
    // field naturally yields "no write" because wreg is taken from it.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        alu_result = '0;
        wreg_sel   = '0;
        case (bus.op_e1)
            OP_R: begin
                wreg_sel = bus.rd_e1;
                case (func)
                    FN_ADD:  alu_result = bus.os_e1 + bus.ot_e1;
                    FN_SUB:  alu_result = bus.os_e1 - bus.ot_e1;
                    FN_AND:  alu_result = bus.os_e1 & bus.ot_e1;
                    FN_OR:   alu_result = bus.os_e1 | bus.ot_e1;
                    FN_XOR:  alu_result = bus.os_e1 ^ bus.ot_e1;
                    FN_NOR:  alu_result = ~(bus.os_e1 | bus.ot_e1);
                    FN_SLL:  alu_result = bus.ot_e1 << shamt;
                    FN_SRL:  alu_result = bus.ot_e1 >> shamt;
                    FN_SRA:  alu_result = word_t'($signed(bus.ot_e1) >>> shamt);
                    default: wreg_sel   = '0;
                endcase
            end
            OP_ADDI: begin
                alu_result = bus.os_e1 + bus.imm_dpl_e1;
                wreg_sel   = bus.rt_e1;
            end
            OP_LUI: begin
                alu_result = {bus.imm_dpl_e1[15:0], 16'h0000};
                wreg_sel   = bus.rt_e1;
            end
            OP_ANDI: begin
                alu_result = bus.os_e1 & {16'h0000, bus.imm_dpl_e1[15:0]};
                wreg_sel   = bus.rt_e1;
            end
            OP_ORI: begin
                alu_result = bus.os_e1 | {16'h0000, bus.imm_dpl_e1[15:0]};
                wreg_sel   = bus.rt_e1;
            end
            OP_XORI: begin
                alu_result = bus.os_e1 ^ {16'h0000, bus.imm_dpl_e1[15:0]};
                wreg_sel   = bus.rt_e1;
            end
            OP_LW, OP_LH, OP_LB: begin
                alu_result = bus.os_e1 + bus.imm_dpl_e1;
                wreg_sel   = bus.rt_e1;
            end
            OP_SW, OP_SH, OP_SB: begin
                alu_result = bus.os_e1 + bus.imm_dpl_e1;
            end
            OP_JAL: begin
                alu_result = bus.pc_e1 + 32'd4;
                wreg_sel   = JAL_LINK;
            end
            default: ;  // branches, jumps, halt, undefined: no result, no write
        endcase
    end

    assign bus.alu_result_e1 = alu_result;
    assign bus.wreg_alu      = wreg_sel;

    // ------------------------------------------------------------------
    // E2 pipeline register
    // ------------------------------------------------------------------
    opcode_t  op_e2_q;
    reg_idx_t wreg_e2_q;
    word_t    ot_e2_q;
    word_t    alu_e2_q;

    // Capture E1 every cycle; reset empties the stage
    always_ff @(posedge sysclk) begin
        if (cpu_reset) begin
            op_e2_q   <= '0;
            wreg_e2_q <= '0;
            ot_e2_q   <= '0;
            alu_e2_q  <= '0;
        end else begin
            op_e2_q   <= bus.op_e1;
            wreg_e2_q <= wreg_sel;
            ot_e2_q   <= bus.ot_e1;
            alu_e2_q  <= alu_result;
        end
    end

    // ------------------------------------------------------------------
    // E2 data memory
    // ------------------------------------------------------------------
    logic [AW-1:0] word_idx;
    logic [1:0]    byte_off;
    logic [3:0]    lane_we;
    word_t         wdata;
    word_t         rdata;

    assign word_idx = alu_e2_q[AW+1:2];
    assign byte_off = alu_e2_q[1:0];

    // Lane enables and replicated write data for the store in E2; a reset
    // at the closing edge cancels the write
    always_comb begin
        lane_we = '0;
        wdata   = '0;
        case (op_e2_q)
            OP_SW: begin
                lane_we = 4'b1111;
                wdata   = ot_e2_q;
            end
            OP_SH: begin
                lane_we = byte_off[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{ot_e2_q[15:0]}};
            end
            OP_SB: begin
                lane_we = 4'b0001 << byte_off;
                wdata   = {4{ot_e2_q[7:0]}};
            end
            default: ;
        endcase
        if (cpu_reset || !is_store(op_e2_q)) begin
            lane_we = '0;
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_lane
        dmem_lane #(
            .DEPTH (DM_WORDS),
            .AW    (AW)
        ) u_lane (
            .sysclk  (sysclk),
            .we      (lane_we[k]),
            .addr    (word_idx),
            .wdata   (wdata[8*k +: 8]),
            .rdata   (rdata[8*k +: 8])
`ifdef DMEM_PROBE_EN
            ,
            .probe_a (dm133[8*k +: 8]),
            .probe_b (dm144[8*k +: 8]),
            .probe_c (dm225[8*k +: 8])
`endif
        );
    end

    // ------------------------------------------------------------------
    // E2 result mux
    // ------------------------------------------------------------------
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;
    word_t       result;

    assign half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];
    assign byte_sel = rdata[8*byte_off +: 8];

    // Select load data (sign-extended for lh/lb) or the registered ALU result
    always_comb begin
        result = alu_e2_q;
        case (op_e2_q)
            OP_LW:   result = rdata;
            OP_LH:   result = {{16{half_sel[15]}}, half_sel};
            OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            default: ;
        endcase
    end

    assign bus.op_e2     = op_e2_q;
    assign bus.wreg_e2   = wreg_e2_q;
    assign bus.result_e2 = result;

endmodule

// File: tb/tb_exec_mem_unit.sv
// Directed bench for exec_mem_unit: ALU operations checked combinationally
// in E1 and one cycle later in E2, then a store/load sequence over the data
// memory and a reset that lands on a store in E2.
// Define DMEM_PROBE_EN to also check the memory probe ports.
module tb_exec_mem_unit;
    import exec_mem_unit_pkg::*;

    logic sysclk = 1'b0;
    logic cpu_reset;
    int   n_checks = 0;
    int   n_errors = 0;

    exec_mem_unit_if bus ();

`ifdef DMEM_PROBE_EN
    word_t dm133, dm144, dm225;
`endif

    exec_mem_unit #(
        .DM_WORDS (256),
        .JAL_LINK (5'd31)
    ) dut (
        .sysclk    (sysclk),
        .cpu_reset (cpu_reset),
        .bus       (bus)
`ifdef DMEM_PROBE_EN
        ,
        .dm133     (dm133),
        .dm144     (dm144),
        .dm225     (dm225)
`endif
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle away from it
    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic issue(input opcode_t op, input reg_idx_t rt, input reg_idx_t rd,
                         input logic [4:0] shamt, input func_t func,
                         input word_t os, input word_t ot, input word_t imm, input word_t pc);
        bus.op_e1      = op;
        bus.rt_e1      = rt;
        bus.rd_e1      = rd;
        bus.aux_e1     = {shamt, func};
        bus.os_e1      = os;
        bus.ot_e1      = ot;
        bus.imm_dpl_e1 = imm;
        bus.pc_e1      = pc;
        #1;
    endtask

    task automatic r_op(input func_t func, input reg_idx_t rd, input logic [4:0] shamt,
                        input word_t os, input word_t ot);
        issue(OP_R, 5'd0, rd, shamt, func, os, ot, 32'd0, 32'd0);
    endtask

    task automatic i_op(input opcode_t op, input reg_idx_t rt, input word_t os,
                        input word_t imm, input word_t ot);
        issue(op, rt, 5'd0, 5'd0, 6'd0, os, ot, imm, 32'd0);
    endtask

    // Watchdog: the directed sequence is short; anything this long is a hang
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        cpu_reset = 1'b1;
        issue(6'd0, 5'd0, 5'd0, 5'd0, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        tick();
        check("rst_op_e2",     32'(bus.op_e2),   32'd0);
        check("rst_wreg_e2",   32'(bus.wreg_e2), 32'd0);
        check("rst_result_e2", bus.result_e2,    32'd0);
        cpu_reset = 1'b0;

        // add 7+5 -> r3, then visible in E2
        r_op(FN_ADD, 5'd3, 5'd0, 32'd7, 32'd5);
        check("add_alu",  bus.alu_result_e1, 32'd12);
        check("add_wreg", 32'(bus.wreg_alu), 32'd3);
        tick();
        check("add_res_e2",  bus.result_e2,      32'd12);
        check("add_wreg_e2", 32'(bus.wreg_e2),   32'd3);

        r_op(FN_SUB, 5'd4, 5'd0, 32'd5, 32'd7);
        check("sub_alu", bus.alu_result_e1, 32'hFFFF_FFFE);
        r_op(FN_SRA, 5'd4, 5'd4, 32'd0, 32'h8000_0000);
        check("sra_alu", bus.alu_result_e1, 32'hF800_0000);
        r_op(FN_SRL, 5'd4, 5'd4, 32'd0, 32'h8000_0000);
        check("srl_alu", bus.alu_result_e1, 32'h0800_0000);
        r_op(FN_SLL, 5'd4, 5'd31, 32'd0, 32'd1);
        check("sll_alu", bus.alu_result_e1, 32'h8000_0000);
        r_op(FN_NOR, 5'd4, 5'd0, 32'h0F0F_0000, 32'h0000_00F0);
        check("nor_alu", bus.alu_result_e1, 32'hF0F0_FF0F);
        r_op(6'd1, 5'd4, 5'd0, 32'd7, 32'd5);
        check("badfn_alu",  bus.alu_result_e1,   32'd0);
        check("badfn_wreg", 32'(bus.wreg_alu),   32'd0);

        // I-type
        i_op(OP_ADDI, 5'd0, 32'd10, 32'hFFFF_FFFD, 32'd0);
        check("addi_r0_wreg", 32'(bus.wreg_alu), 32'd0);
        i_op(OP_ADDI, 5'd5, 32'd10, 32'hFFFF_FFFD, 32'd0);
        check("addi_alu",  bus.alu_result_e1,  32'd7);
        check("addi_wreg", 32'(bus.wreg_alu),  32'd5);
        i_op(OP_LUI, 5'd6, 32'd0, 32'h0000_1234, 32'd0);
        check("lui_alu", bus.alu_result_e1, 32'h1234_0000);
        i_op(OP_ANDI, 5'd6, 32'hFFFF_FFFF, 32'hFFFF_8001, 32'd0);
        check("andi_alu", bus.alu_result_e1, 32'h0000_8001);
        i_op(OP_ORI, 5'd6, 32'hF000_0000, 32'h0000_000F, 32'd0);
        check("ori_alu", bus.alu_result_e1, 32'hF000_000F);
        i_op(OP_XORI, 5'd6, 32'd0, 32'hFFFF_8000, 32'd0);
        check("xori_alu", bus.alu_result_e1, 32'h0000_8000);

        // jal and halt
        issue(OP_JAL, 5'd0, 5'd0, 5'd0, 6'd0, 32'd0, 32'd0, 32'd0, 32'd100);
        check("jal_alu",  bus.alu_result_e1, 32'd104);
        check("jal_wreg", 32'(bus.wreg_alu), 32'd31);
        tick();
        check("jal_res_e2", bus.result_e2,    32'd104);
        check("jal_op_e2",  32'(bus.op_e2),   32'(OP_JAL));
        issue(OP_HALT, 5'd7, 5'd7, 5'd0, 6'd0, 32'd3, 32'd3, 32'd3, 32'd200);
        check("halt_wreg", 32'(bus.wreg_alu),   32'd0);
        check("halt_alu",  bus.alu_result_e1,   32'd0);

        // sw to 528+4, then lw from 532
        i_op(OP_SW, 5'd9, 32'd528, 32'd4, 32'h0000_0315);
        check("sw_addr", bus.alu_result_e1, 32'd532);
        check("sw_wreg", 32'(bus.wreg_alu), 32'd0);
        tick();
        i_op(OP_LW, 5'd7, 32'd532, 32'd0, 32'd0);
        tick();
        check("lw_532",      bus.result_e2,    32'h0000_0315);
        check("lw_wreg_e2",  32'(bus.wreg_e2), 32'd7);
`ifdef DMEM_PROBE_EN
        check("probe_dm133", dm133, 32'h0000_0315);
`endif

        // word 225: full word, then byte, halfword, and sub-word loads
        i_op(OP_SW, 5'd0, 32'd900, 32'd0, 32'h1122_3344);
        tick();
        i_op(OP_SB, 5'd0, 32'd900, 32'd1, 32'h0000_0080);
        tick();
        i_op(OP_LB, 5'd8, 32'd900, 32'd1, 32'd0);
        tick();
        check("lb_901", bus.result_e2, 32'hFFFF_FF80);
        i_op(OP_LW, 5'd8, 32'd900, 32'd0, 32'd0);
        tick();
        check("lw_900_after_sb", bus.result_e2, 32'h1122_8044);
        i_op(OP_SH, 5'd0, 32'd900, 32'd2, 32'h0000_ABCD);
        tick();
        i_op(OP_LH, 5'd8, 32'd902, 32'd0, 32'd0);
        tick();
        check("lh_902", bus.result_e2, 32'hFFFF_ABCD);
        i_op(OP_LH, 5'd8, 32'd900, 32'd0, 32'd0);
        tick();
        check("lh_900", bus.result_e2, 32'hFFFF_8044);
        i_op(OP_LB, 5'd8, 32'd900, 32'd0, 32'd0);
        tick();
        check("lb_900", bus.result_e2, 32'h0000_0044);
`ifdef DMEM_PROBE_EN
        check("probe_dm225", dm225, 32'hABCD_8044);
`endif

        // load in E2 while the next store is still in E1 reads old data
        i_op(OP_LW, 5'd8, 32'd900, 32'd0, 32'd0);
        tick();
        i_op(OP_SW, 5'd0, 32'd903, 32'd0, 32'hCAFE_BABE);   // unaligned: word 225
        check("lw_old_data", bus.result_e2, 32'hABCD_8044);
        tick();
        i_op(OP_LW, 5'd8, 32'd901, 32'd0, 32'd0);           // unaligned read
        tick();
        check("lw_unaligned", bus.result_e2, 32'hCAFE_BABE);

        // sh to the low half of word 144 leaves the high half alone
        i_op(OP_SW, 5'd0, 32'd576, 32'd0, 32'h0000_0000);
        tick();
        i_op(OP_SH, 5'd0, 32'd576, 32'd0, 32'h1234_8765);
        tick();
        i_op(OP_LW, 5'd8, 32'd576, 32'd0, 32'd0);
        tick();
        check("sh_low_half", bus.result_e2, 32'h0000_8765);
`ifdef DMEM_PROBE_EN
        check("probe_dm144", dm144, 32'h0000_8765);
`endif

        // reset while a sw sits in E2 cancels the write
        i_op(OP_SW, 5'd0, 32'd532, 32'd0, 32'hDEAD_BEEF);
        tick();
        cpu_reset = 1'b1;
        issue(6'd0, 5'd0, 5'd0, 5'd0, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        check("rst_sw_op_e2",     32'(bus.op_e2),   32'd0);
        check("rst_sw_wreg_e2",   32'(bus.wreg_e2), 32'd0);
        check("rst_sw_result_e2", bus.result_e2,    32'd0);
        cpu_reset = 1'b0;
        i_op(OP_LW, 5'd7, 32'd532, 32'd0, 32'd0);
        tick();
        check("rst_sw_mem_kept", bus.result_e2, 32'h0000_0315);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
